// File: rtl/eth_pkg.sv
// Shared Ethernet-domain types: OutFIFO status/command records, pointer and
// length types, and the transmit-sequencer state encoding.
package eth_pkg;

  localparam int ETH_OUTFIFO_KB_SIZE = 2;
  localparam int ETH_OUTFIFO_BYTES   = ETH_OUTFIFO_KB_SIZE * 1024;
  // One extra bit so a completely full OutFIFO is distinguishable from empty.
  localparam int ETH_PTR_W           = $clog2(ETH_OUTFIFO_BYTES) + 1;
  localparam int ETH_TX_REQ_SLOTS    = 4;

  typedef logic [ETH_PTR_W-1:0] ptr_t;
  typedef logic [15:0]          udp_length_t;

  typedef struct packed {
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic empty;
    logic full;
    logic done;
  } s_fifo_st_t;

  typedef struct packed {
    logic        start;
    udp_length_t length;
    logic        clear;
  } s_fifo_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DATA,
    START,
    RELEASE
  } fsm_tx_sched_t;

  // Bytes present in the OutFIFO; modulo subtraction absorbs pointer wrap.
  function automatic ptr_t ptr_avail(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr - rd_ptr;
  endfunction

endpackage

// File: rtl/eth_fifo.sv
// Small synchronous FIFO with a synchronous clear; first-word fall-through
// read port (data_o shows the head whenever empty_o is low).
module eth_fifo #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_eth,
  input  logic             rst_eth,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(SLOTS);

  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: storage is deliberately left out of reset; a slot is only ever read
  // after it has been written, so resetting it would only cost flops.
  always_ff @(posedge clk_eth) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_eth) begin
    if (rst_eth || clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// OutFIFO packet-send sequencer: queues byte-length requests and issues each as
// a start/length/done handshake once enough bytes are present.
// Optional START watchdog: define ETH_TX_SCHED_TIMEOUT_EN.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int REQ_SLOTS      = ETH_TX_REQ_SLOTS,
  parameter int FIFO_BYTES     = ETH_OUTFIFO_BYTES,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_eth,
  input  logic        rst_eth,
  input  logic        req_valid_i,
  input  udp_length_t req_len_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  input  s_fifo_st_t  fifo_st_i,
  output s_fifo_cmd_t fifo_cmd_o,
  output logic        busy_o,
  output logic        pkt_sent_o,
  output logic [15:0] sent_cnt_o,
  output logic        err_o
);

  fsm_tx_sched_t state_q;
  udp_length_t   len_q;
  logic          start_q;
  logic          clear_q;
  logic          pkt_sent_q;
  logic          err_q;
  logic [15:0]   sent_cnt_q;

  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;
  udp_length_t   q_head;

  logic          accept;
  logic          reject;
  ptr_t          avail;
  logic          avail_ok;
  logic          unused_st;

  assign req_ready_o = !q_full && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign reject      = accept &&
                       ((req_len_i == '0) || (32'(req_len_i) > 32'(FIFO_BYTES)));
  assign q_push      = accept && !reject;
  assign q_pop       = (state_q == LOAD);

  assign avail       = ptr_avail(fifo_st_i.wr_ptr, fifo_st_i.rd_ptr);
  assign avail_ok    = udp_length_t'(avail) >= len_q;
  // The gating decision uses pointers only; the FIFO's own flags are informational.
  assign unused_st   = fifo_st_i.empty ^ fifo_st_i.full;

  eth_fifo #(
    .SLOTS (REQ_SLOTS),
    .WIDTH ($bits(udp_length_t))
  ) u_req_q (
    .clk_eth (clk_eth),
    .rst_eth (rst_eth),
    .clear_i (flush_i),
    .push_i  (q_push),
    .data_i  (req_len_i),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  always_ff @(posedge clk_eth) begin
    if (rst_eth) begin
      state_q    <= IDLE;
      len_q      <= '0;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      pkt_sent_q <= 1'b0;
      err_q      <= 1'b0;
      sent_cnt_q <= '0;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      clear_q    <= 1'b0;
      pkt_sent_q <= 1'b0;
      err_q      <= reject;

      // Flush beats everything, including a done arriving in the same cycle.
      if (flush_i) begin
        state_q <= IDLE;
        start_q <= 1'b0;
        clear_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!q_empty) state_q <= LOAD;
          end
          LOAD: begin
            len_q   <= q_head;
            state_q <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (avail_ok) begin
              start_q  <= 1'b1;
              state_q  <= START;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
          START: begin
            if (fifo_st_i.done) begin
              start_q    <= 1'b0;
              pkt_sent_q <= 1'b1;
              sent_cnt_q <= sent_cnt_q + 16'd1;
              state_q    <= RELEASE;
            end
`ifdef ETH_TX_SCHED_TIMEOUT_EN
            // Watchdog abort clears the OutFIFO but keeps the request queue.
            else if (to_cnt_q == TO_LAST) begin
              start_q <= 1'b0;
              clear_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
          end
          RELEASE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_cmd_o = '{start: start_q, length: len_q, clear: clear_q};
  assign busy_o     = (state_q != IDLE) || !q_empty;
  assign pkt_sent_o = pkt_sent_q;
  assign sent_cnt_o = sent_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed scenarios plus randomized
// requests against an in-order request model and an OutFIFO pointer model.
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam int FB = ETH_OUTFIFO_BYTES;

  logic        clk_eth   = 1'b0;
  logic        rst_eth   = 1'b1;
  logic        req_valid = 1'b0;
  udp_length_t req_len   = '0;
  logic        flush     = 1'b0;
  logic        req_ready;
  s_fifo_st_t  fifo_st;
  s_fifo_cmd_t fifo_cmd;
  logic        busy;
  logic        pkt_sent;
  logic [15:0] sent_cnt;
  logic        err;

  int          n_tests = 0;
  int          n_fail  = 0;
  udp_length_t exp_q[$];
  int          exp_sent = 0;

  always #5 clk_eth = ~clk_eth;

  eth_tx_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk_eth     (clk_eth),
    .rst_eth     (rst_eth),
    .req_valid_i (req_valid),
    .req_len_i   (req_len),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .fifo_st_i   (fifo_st),
    .fifo_cmd_o  (fifo_cmd),
    .busy_o      (busy),
    .pkt_sent_o  (pkt_sent),
    .sent_cnt_o  (sent_cnt),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_eth);
  endtask

  task automatic set_avail(input int n);
    fifo_st.wr_ptr = fifo_st.rd_ptr + ptr_t'(n);
    fifo_st.empty  = (n == 0);
    fifo_st.full   = (n == FB);
  endtask

  // OutFIFO clear empties the byte store.
  task automatic fifo_cleared();
    fifo_st.rd_ptr = fifo_st.wr_ptr;
    fifo_st.empty  = 1'b1;
    fifo_st.full   = 1'b0;
  endtask

  task automatic push(input int len, output bit acc);
    bit bad;
    req_valid = 1'b1;
    req_len   = udp_length_t'(len);
    #1;
    acc = req_ready;
    tick();
    req_valid = 1'b0;
    bad = (len == 0) || (len > FB);
    check("err_pulse", 32'(err), 32'(acc && bad));
    if (acc && !bad) exp_q.push_back(udp_length_t'(len));
  endtask

  task automatic wait_start(output bit seen);
    int n = 0;
    while (fifo_cmd.start !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    seen = (fifo_cmd.start === 1'b1);
    check("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic serve_one(input udp_length_t len);
    bit seen;
    bit stable;
    int hold;
    wait_start(seen);
    if (!seen) return;
    check("cmd_length", 32'(fifo_cmd.length), 32'(len));
    stable = 1'b1;
    hold   = $urandom_range(1, 6);
    repeat (hold) begin
      tick();
      if (fifo_cmd.start !== 1'b1 || fifo_cmd.length !== len || pkt_sent !== 1'b0)
        stable = 1'b0;
    end
    check("start_hold", 32'(stable), 32'd1);
    fifo_st.done = 1'b1;
    tick();
    fifo_st.done   = 1'b0;
    fifo_st.rd_ptr = fifo_st.rd_ptr + ptr_t'(len);
    exp_sent++;
    check("release_start", 32'(fifo_cmd.start), 32'd0);
    check("pkt_sent", 32'(pkt_sent), 32'd1);
    check("sent_cnt", 32'(sent_cnt), 32'(16'(exp_sent)));
    tick();
    check("gap_start", 32'(fifo_cmd.start), 32'd0);
    check("pkt_sent_once", 32'(pkt_sent), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit seen;
    bit quiet;
    int len;
    int low;
    int r;
    int hi_cnt;

    fifo_st        = '0;
    fifo_st.rd_ptr = ptr_t'($urandom);
    fifo_cmd_init: begin end
    set_avail(0);

    // Reset state
    repeat (3) tick();
    rst_eth = 1'b0;
    #1;
    check("rst_cmd", 32'(fifo_cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
    check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    tick();

    // Exactly-enough bytes
    set_avail(64);
    push(64, acc);
    serve_one(exp_q.pop_front());

    // Start gated until enough bytes arrive
    set_avail(40);
    push(100, acc);
    quiet = 1'b1;
    repeat (50) begin
      tick();
      if (fifo_cmd.start !== 1'b0) quiet = 1'b0;
    end
    check("gate_hold_100", 32'(quiet), 32'd1);
    set_avail(100);
    tick();
    check("start_next_cycle", 32'(fifo_cmd.start), 32'd1);
    serve_one(exp_q.pop_front());

    // Rejected lengths
    set_avail(FB);
    push(0, acc);
    check("rej0_accepted", 32'(acc), 32'd1);
    tick();
    check("rej0_err_once", 32'(err), 32'd0);
    check("rej0_busy", 32'(busy), 32'd0);
    push(FB + 1, acc);
    tick();
    check("rejbig_busy", 32'(busy), 32'd0);
    check("rejbig_start", 32'(fifo_cmd.start), 32'd0);

    // Queue full: head parked in WAIT_DATA, four more fill the queue
    set_avail(0);
    push(5, acc);
    repeat (4) tick();
    for (int i = 1; i <= 4; i++) begin
      push(10 * i, acc);
      check("ready_fill", 32'(acc), 32'd1);
    end
    push(50, acc);
    check("ready_full", 32'(acc), 32'd0);
    set_avail(FB);
    while (exp_q.size() > 0) serve_one(exp_q.pop_front());
    check("sent_after_fill", 32'(sent_cnt), 32'(16'(exp_sent)));

    // Flush mid-START with two requests queued, done coinciding
    set_avail(FB);
    push(30, acc);
    push(40, acc);
    push(50, acc);
    wait_start(seen);
    repeat (10) begin
      tick();
      if (fifo_cmd.start !== 1'b1) seen = 1'b0;
    end
    check("start_waits", 32'(seen), 32'd1);
    flush        = 1'b1;
    fifo_st.done = 1'b1;
    #1;
    check("ready_flush", 32'(req_ready), 32'd0);
    tick();
    flush        = 1'b0;
    fifo_st.done = 1'b0;
    fifo_cleared();
    exp_q.delete();
    check("flush_clear", 32'(fifo_cmd.clear), 32'd1);
    check("flush_start", 32'(fifo_cmd.start), 32'd0);
    check("flush_no_sent", 32'(pkt_sent), 32'd0);
    tick();
    check("flush_clear_once", 32'(fifo_cmd.clear), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_cnt", 32'(sent_cnt), 32'(16'(exp_sent)));
    fifo_st.done = 1'b1;
    tick();
    fifo_st.done = 1'b0;
    check("idle_done_ignored", 32'(pkt_sent), 32'd0);
    tick();

`ifdef ETH_TX_SCHED_TIMEOUT_EN
    // Watchdog abort, then the queued request proceeds
    set_avail(FB);
    push(20, acc);
    push(25, acc);
    wait_start(seen);
    hi_cnt = 0;
    while (fifo_cmd.start === 1'b1 && hi_cnt < 100) begin
      hi_cnt++;
      tick();
    end
    check("to_start_cycles", 32'(hi_cnt), 32'd16);
    check("to_clear", 32'(fifo_cmd.clear), 32'd1);
    check("to_err", 32'(err), 32'd1);
    void'(exp_q.pop_front());
    fifo_cleared();
    set_avail(FB);
    serve_one(exp_q.pop_front());
`endif

    // Randomized requests
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 1) len = FB + 1 + $urandom_range(0, 100);
      else if (r == 2) len = FB;
      else             len = $urandom_range(1, FB);
      if (len >= 1 && len <= FB) begin
        low = $urandom_range(0, len - 1);
        set_avail(low);
        push(len, acc);
        quiet = 1'b1;
        repeat ($urandom_range(0, 10)) begin
          tick();
          if (fifo_cmd.start !== 1'b0) quiet = 1'b0;
        end
        check("rand_gate", 32'(quiet), 32'd1);
        set_avail(len + $urandom_range(0, FB - len));
        serve_one(exp_q.pop_front());
      end else begin
        push(len, acc);
        tick();
        check("rand_rej_busy", 32'(busy), 32'd0);
      end
    end
    check("rand_cnt", 32'(sent_cnt), 32'(16'(exp_sent)));

    // Reset mid-packet
    set_avail(FB);
    push(77, acc);
    wait_start(seen);
    rst_eth = 1'b1;
    tick();
    check("rst_mid_start", 32'(fifo_cmd.start), 32'd0);
    check("rst_mid_cnt", 32'(sent_cnt), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst_eth = 1'b0;
    exp_q.delete();
    exp_sent = 0;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
